// File: rtl/ctrl_burst_data.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_burst_data
// Brief    : DDR data-phase sequencer. Queues issued CAS commands, waits the
//            per-command latency, then drives or captures one data burst.
//            Optional macro WR_PREAMBLE_EN adds a one-cycle DQS write preamble.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_burst_data #(
    parameter int DQ_W    = 8,
    parameter int BL_MAX  = 8,
    parameter int Q_DEPTH = 4
) (
    input  logic                   CK_t,
    input  logic                   reset,
    input  logic                   cas_rdy,
    input  logic [2:0]             cas_req,
    input  logic [DQ_W*BL_MAX-1:0] wr_data,
    input  logic [4:0]             CL,
    input  logic [4:0]             CWL,
    input  logic [4:0]             AL,
    input  logic [3:0]             BL,
    input  logic [2*DQ_W-1:0]      dq_in,
    output logic [2*DQ_W-1:0]      dq_out,
    output logic                   dq_oe,
    output logic                   dqs_oe,
    output logic [DQ_W*BL_MAX-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   rw_done,
    output logic                   data_busy,
    output logic                   ovf_err,
    output logic                   conflict_err
);

    localparam int c_DATA_W    = DQ_W * BL_MAX;
    localparam int c_PAIR_BITS = 2 * DQ_W;
    localparam int c_PAIRS     = BL_MAX / 2;
    localparam int c_PAIR_W    = (c_PAIRS > 1) ? $clog2(c_PAIRS) : 1;
    localparam int c_PTR_W     = $clog2(Q_DEPTH);
    localparam int c_CNT_W     = c_PTR_W + 1;

    localparam logic [c_PAIR_W-1:0] c_LAST_BL8 = c_PAIR_W'(c_PAIRS - 1);
    localparam logic [c_PAIR_W-1:0] c_LAST_BL4 = c_PAIR_W'(1);
    localparam logic [c_DATA_W-1:0] c_BL4_MASK = {c_DATA_W{1'b1}} >> (c_DATA_W - 4 * DQ_W);

    // Request encodings shared with the CAS stage (ddr_pkg WR_R / WRA_R)
    localparam logic [2:0] c_WR_R  = 3'd3;
    localparam logic [2:0] c_WRA_R = 3'd4;

    localparam logic [1:0] D_IDLE  = 2'd0;
    localparam logic [1:0] D_PRE   = 2'd1;
    localparam logic [1:0] D_BURST = 2'd2;
    localparam logic [1:0] D_POST  = 2'd3;

    // In-flight command queue
    logic                r_q_wr   [Q_DEPTH];
    logic                r_q_bl4  [Q_DEPTH];
    logic [5:0]          r_q_cnt  [Q_DEPTH];
    logic [c_DATA_W-1:0] r_q_data [Q_DEPTH];
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_ovf;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                w_start;

    logic                r_cur_wr;
    logic                r_cur_bl4;
    logic [c_DATA_W-1:0] r_cur_data;
    logic [c_PAIR_W-1:0] r_pair;
    logic [c_DATA_W-1:0] r_rd_buf;
    logic [c_DATA_W-1:0] r_rd_data;
    logic [c_DATA_W-1:0] w_rd_merged;
    logic                r_conf_flag;

    logic                w_is_wr;
    logic [5:0]          w_lat_sum;
    logic [5:0]          w_lat;
    logic [5:0]          w_load;
    logic                w_full;
    logic                w_head_due;
    logic                w_head_pre;
    logic                w_enq;
    logic                w_deq;
    logic                w_last_pair;
    logic                w_active;
    logic                w_conflict;

    assign w_is_wr   = (cas_req == c_WR_R) || (cas_req == c_WRA_R);
    assign w_lat_sum = {1'b0, AL} + {1'b0, (w_is_wr ? CWL : CL)};
    assign w_lat     = (w_lat_sum < 6'd2) ? 6'd2 : w_lat_sum;

`ifdef WR_PREAMBLE_EN
    // Writes become due one cycle early so the preamble cycle keeps beat timing
    assign w_load     = w_is_wr ? (w_lat - 6'd2) : (w_lat - 6'd1);
    assign w_head_pre = r_q_wr[r_head];
`else
    assign w_load     = w_lat - 6'd1;
    assign w_head_pre = 1'b0;
`endif

    assign w_full      = (r_count == c_CNT_W'(Q_DEPTH));
    assign w_head_due  = (r_count != '0) && (r_q_cnt[r_head] == 6'd0);
    assign w_deq       = w_start;
    assign w_enq       = cas_rdy && (!w_full || w_deq);
    assign w_last_pair = (r_pair == (r_cur_bl4 ? c_LAST_BL4 : c_LAST_BL8));
    assign w_active    = (r_state == D_PRE) || (r_state == D_BURST);
    assign w_conflict  = w_active && w_head_due && !r_conf_flag;

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                r_q_wr[i]   <= 1'b0;
                r_q_bl4[i]  <= 1'b0;
                r_q_cnt[i]  <= 6'd0;
                r_q_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                if (w_enq && (r_tail == c_PTR_W'(i))) begin
                    r_q_wr[i]   <= w_is_wr;
                    r_q_bl4[i]  <= (BL == 4'd4);
                    r_q_cnt[i]  <= w_load;
                    r_q_data[i] <= wr_data;
                end else if (r_q_cnt[i] != 6'd0) begin
                    r_q_cnt[i] <= r_q_cnt[i] - 6'd1;
                end
            end
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - 1'b1;
            end
            if (cas_rdy && !w_enq) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            r_state <= D_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            D_IDLE, D_POST: begin
                if (w_head_due) begin
                    w_start     = 1'b1;
                    w_state_nxt = w_head_pre ? D_PRE : D_BURST;
                end else begin
                    w_state_nxt = D_IDLE;
                end
            end
            D_PRE: begin
                w_state_nxt = D_BURST;
            end
            D_BURST: begin
                if (w_last_pair) begin
                    w_state_nxt = D_POST;
                end
            end
            default: begin
                w_state_nxt = D_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_merged = r_rd_buf;
        w_rd_merged[r_pair*c_PAIR_BITS +: c_PAIR_BITS] = dq_in;
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            r_cur_wr    <= 1'b0;
            r_cur_bl4   <= 1'b0;
            r_cur_data  <= '0;
            r_pair      <= '0;
            r_rd_buf    <= '0;
            r_rd_data   <= '0;
            r_conf_flag <= 1'b0;
        end else begin
            if (w_start) begin
                r_cur_wr   <= r_q_wr[r_head];
                r_cur_bl4  <= r_q_bl4[r_head];
                r_cur_data <= r_q_data[r_head];
                r_pair     <= '0;
            end else if (r_state == D_BURST) begin
                r_pair <= r_pair + 1'b1;
                if (!r_cur_wr) begin
                    r_rd_buf <= w_rd_merged;
                    if (w_last_pair) begin
                        r_rd_data <= r_cur_bl4 ? (w_rd_merged & c_BL4_MASK) : w_rd_merged;
                    end
                end
            end
            // One conflict report per waiting head entry
            if (w_start) begin
                r_conf_flag <= 1'b0;
            end else if (w_conflict) begin
                r_conf_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        dq_oe        = 1'b0;
        dqs_oe       = 1'b0;
        dq_out       = '0;
        rw_done      = 1'b0;
        rd_valid     = 1'b0;
        conflict_err = w_conflict;
        data_busy    = (r_count != '0) || (r_state != D_IDLE);
        case (r_state)
            D_PRE: begin
                dqs_oe = 1'b1;
            end
            D_BURST: begin
                if (r_cur_wr) begin
                    dq_oe  = 1'b1;
                    dqs_oe = 1'b1;
                    dq_out = r_cur_data[r_pair*c_PAIR_BITS +: c_PAIR_BITS];
                end
            end
            D_POST: begin
                rw_done  = 1'b1;
                rd_valid = !r_cur_wr;
            end
            default: begin
                dq_oe = 1'b0;
            end
        endcase
    end

    assign rd_data = r_rd_data;
    assign ovf_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_burst_data.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_burst_data
// Brief    : Directed self-checking bench for ctrl_burst_data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_burst_data;

    localparam logic [2:0] c_RD = 3'd1;
    localparam logic [2:0] c_WR = 3'd3;
`ifdef WR_PREAMBLE_EN
    localparam int c_GAP = 6;
`else
    localparam int c_GAP = 5;
`endif

    logic        CK_t = 1'b0;
    logic        reset = 1'b1;
    logic        cas_rdy = 1'b0;
    logic [2:0]  cas_req = 3'd0;
    logic [63:0] wr_data = '0;
    logic [4:0]  CL = '0;
    logic [4:0]  CWL = '0;
    logic [4:0]  AL = '0;
    logic [3:0]  BL = 4'd8;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        dqs_oe;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        rw_done;
    logic        data_busy;
    logic        ovf_err;
    logic        conflict_err;

    int cyc = 0;
    int t0 = 0;
    int checks = 0;
    int errors = 0;

    ctrl_burst_data #(.DQ_W(8), .BL_MAX(8), .Q_DEPTH(4)) dut (
        .CK_t(CK_t), .reset(reset), .cas_rdy(cas_rdy), .cas_req(cas_req),
        .wr_data(wr_data), .CL(CL), .CWL(CWL), .AL(AL), .BL(BL), .dq_in(dq_in),
        .dq_out(dq_out), .dq_oe(dq_oe), .dqs_oe(dqs_oe), .rd_data(rd_data),
        .rd_valid(rd_valid), .rw_done(rw_done), .data_busy(data_busy),
        .ovf_err(ovf_err), .conflict_err(conflict_err)
    );

    always #5 CK_t = ~CK_t;
    always @(posedge CK_t) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge CK_t);
            #1;
        end
    endtask

    task automatic apply_reset();
        cas_rdy = 1'b0;
        dq_in   = '0;
        reset   = 1'b1;
        @(posedge CK_t);
        @(posedge CK_t);
        #1;
        reset = 1'b0;
        t0    = cyc;
    endtask

    // Command is sampled on the edge that opens cycle n
    task automatic issue(input int n, input logic [2:0] req, input logic [4:0] al,
                         input logic [4:0] cl, input logic [4:0] cwl,
                         input logic [3:0] bl, input logic [63:0] data);
        goto(t0 + n - 1);
        cas_req = req; AL = al; CL = cl; CWL = cwl; BL = bl; wr_data = data;
        cas_rdy = 1'b1;
        goto(t0 + n);
        cas_rdy = 1'b0;
    endtask

    function automatic logic [15:0] pat(input int c);
        logic [7:0] lo, hi;
        lo = 8'(c + 100);
        hi = 8'(c);
        return {hi, lo};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({dq_oe, dqs_oe, rd_valid, rw_done, data_busy, ovf_err, conflict_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {dq_oe, dqs_oe, rd_valid, rw_done, data_busy, ovf_err, conflict_err});
        end
        checks++;
        if (dq_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_dq_out: got %h expected 0000", dq_out);
        end
        checks++;
        if (rd_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h expected 0", rd_data);
        end
    endtask

    task automatic test_single_write();
        logic [63:0] d;
        logic        e_oe;
        logic [15:0] e_dq;
        int          idx;
        d = 64'h0706050403020100;
        apply_reset();
        issue(10, c_WR, 5'd0, 5'd0, 5'd5, 4'd8, d);
        for (int c = 13; c <= 20; c++) begin
            goto(t0 + c);
            e_oe = (c >= 15) && (c <= 18);
            idx  = e_oe ? (c - 15) : 0;
            e_dq = e_oe ? d[idx*16 +: 16] : 16'h0;
            checks++;
            if (dq_oe !== e_oe || dq_out !== e_dq) begin
                errors++;
                $display("FAIL wr_beat c%0d: got oe=%b dq=%h expected oe=%b dq=%h",
                         c, dq_oe, dq_out, e_oe, e_dq);
            end
            checks++;
            if (rw_done !== (c == 19)) begin
                errors++;
                $display("FAIL wr_done c%0d: got %b expected %b", c, rw_done, (c == 19));
            end
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        issue(10, c_RD, 5'd1, 5'd6, 5'd0, 4'd4, 64'h0);
        goto(t0 + 17);
        dq_in = 16'hBBAA;
        checks++;
        if (dq_oe !== 1'b0 || dqs_oe !== 1'b0) begin
            errors++;
            $display("FAIL rd_oe: got oe=%b dqs=%b expected 0 0", dq_oe, dqs_oe);
        end
        goto(t0 + 18);
        dq_in = 16'hDDCC;
        goto(t0 + 19);
        checks++;
        if (rd_valid !== 1'b1 || rw_done !== 1'b1) begin
            errors++;
            $display("FAIL rd_post: got valid=%b done=%b expected 1 1", rd_valid, rw_done);
        end
        checks++;
        if (rd_data !== 64'h00000000DDCCBBAA) begin
            errors++;
            $display("FAIL rd_data_bl4: got %h expected 00000000ddccbbaa", rd_data);
        end
        goto(t0 + 20);
        dq_in = 16'h0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 64'h00000000DDCCBBAA || data_busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_hold: got valid=%b data=%h busy=%b expected 0 00000000ddccbbaa 0",
                     rd_valid, rd_data, data_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic        e_oe, e_done;
        logic [15:0] e_dq;
        logic [63:0] dk;
        int          off, k, ph, n, dones;
        apply_reset();
        AL = 5'd0; CWL = 5'd9; BL = 4'd8; cas_req = c_WR;
        for (int c = 9; c <= 50; c++) begin
            goto(t0 + c);
            off    = c - 19;
            k      = (off >= 0) ? off / c_GAP : 99;
            ph     = (off >= 0) ? off % c_GAP : 99;
            e_oe   = (k < 5) && (ph < 4);
            e_done = (k < 5) && (ph == 4);
            dk     = 64'h1111111111111111 * 64'((k < 5) ? k + 1 : 0);
            e_dq   = e_oe ? dk[ph*16 +: 16] : 16'h0;
            checks++;
            if (dq_oe !== e_oe || dq_out !== e_dq || rw_done !== e_done) begin
                errors++;
                $display("FAIL b2b c%0d: got oe=%b dq=%h done=%b expected oe=%b dq=%h done=%b",
                         c, dq_oe, dq_out, rw_done, e_oe, e_dq, e_done);
            end
            checks++;
            if (conflict_err !== 1'b0 || ovf_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_err c%0d: got conflict=%b ovf=%b expected 0 0",
                         c, conflict_err, ovf_err);
            end
            n       = c + 1 - 10;
            cas_rdy = (n >= 0) && (n <= 4 * c_GAP) && (n % c_GAP == 0);
            if (cas_rdy) wr_data = 64'h1111111111111111 * 64'(n / c_GAP + 1);
        end
        cas_rdy = 1'b0;
        checks++;
        if (data_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b expected 0", data_busy);
        end

        // Six cas_rdy pulses on consecutive cycles: four fill the queue, two drop
        apply_reset();
        AL = 5'd31; CWL = 5'd31; BL = 4'd8; cas_req = c_WR; wr_data = 64'hA5A5A5A5A5A5A5A5;
        goto(t0 + 9);
        cas_rdy = 1'b1;
        goto(t0 + 13);
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early: got %b expected 0", ovf_err);
        end
        goto(t0 + 14);
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", ovf_err);
        end
        goto(t0 + 15);
        cas_rdy = 1'b0;
        dones = 0;
        for (int c = 16; c <= 100; c++) begin
            goto(t0 + c);
            if (rw_done === 1'b1) dones++;
            if (c == 71 || c == 72) begin
                checks++;
                if (dq_oe !== (c == 72)) begin
                    errors++;
                    $display("FAIL full_first c%0d: got oe=%b expected %b", c, dq_oe, (c == 72));
                end
            end
        end
        checks++;
        if (dones !== 4) begin
            errors++;
            $display("FAIL ovf_drop: got %0d bursts expected 4", dones);
        end
        checks++;
        if (ovf_err !== 1'b1 || data_busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b busy=%b expected 1 0", ovf_err, data_busy);
        end
    endtask

    task automatic test_conflict();
        logic        e_conf, e_done;
        logic [63:0] e_rd;
        apply_reset();
        AL = 5'd0; CL = 5'd5; BL = 4'd8; cas_req = c_RD;
        for (int c = 9; c <= 26; c++) begin
            goto(t0 + c);
            dq_in  = pat(c);
            e_conf = (c == 16);
            e_done = (c == 19) || (c == 24);
            checks++;
            if (conflict_err !== e_conf || rw_done !== e_done || rd_valid !== e_done || dq_oe !== 1'b0) begin
                errors++;
                $display("FAIL conflict c%0d: got conf=%b done=%b valid=%b oe=%b expected conf=%b done=%b valid=%b oe=0",
                         c, conflict_err, rw_done, rd_valid, dq_oe, e_conf, e_done, e_done);
            end
            if (e_done) begin
                for (int p = 0; p < 4; p++) e_rd[p*16 +: 16] = pat(c - 4 + p);
                checks++;
                if (rd_data !== e_rd) begin
                    errors++;
                    $display("FAIL conflict_rd c%0d: got %h expected %h", c, rd_data, e_rd);
                end
            end
            cas_rdy = (c + 1 == 10) || (c + 1 == 12);
        end
        cas_rdy = 1'b0;
        checks++;
        if (data_busy !== 1'b0) begin
            errors++;
            $display("FAIL conflict_idle: got busy=%b expected 0", data_busy);
        end
    endtask

    task automatic test_clamp_latch();
        logic [63:0] e_rd;
        apply_reset();
        issue(10, c_RD, 5'd0, 5'd1, 5'd0, 4'd5, 64'h0);
        CL = 5'd20;
        AL = 5'd7;
        for (int c = 10; c <= 17; c++) begin
            goto(t0 + c);
            dq_in = pat(c);
            checks++;
            if (rd_valid !== (c == 16)) begin
                errors++;
                $display("FAIL clamp_valid c%0d: got %b expected %b", c, rd_valid, (c == 16));
            end
        end
        for (int p = 0; p < 4; p++) e_rd[p*16 +: 16] = pat(12 + p);
        checks++;
        if (rd_data !== e_rd) begin
            errors++;
            $display("FAIL clamp_rd: got %h expected %h", rd_data, e_rd);
        end
    endtask

    task automatic test_reset_midburst();
        apply_reset();
        issue(10, c_WR, 5'd0, 5'd0, 5'd5, 4'd8, 64'h0706050403020100);
        goto(t0 + 16);
        checks++;
        if (dq_oe !== 1'b1 || dq_out !== 16'h0302) begin
            errors++;
            $display("FAIL midburst_pre: got oe=%b dq=%h expected 1 0302", dq_oe, dq_out);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({dq_oe, dqs_oe, rw_done, data_busy, rd_valid, conflict_err, ovf_err} !== 7'b0 || dq_out !== 16'h0) begin
            errors++;
            $display("FAIL midburst_abort: got flags=%b dq=%h expected 0000000 0000",
                     {dq_oe, dqs_oe, rw_done, data_busy, rd_valid, conflict_err, ovf_err}, dq_out);
        end
        @(posedge CK_t);
        @(posedge CK_t);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CK_t);
            #1;
            checks++;
            if (rw_done !== 1'b0 || dq_oe !== 1'b0 || data_busy !== 1'b0) begin
                errors++;
                $display("FAIL midburst_after %0d: got done=%b oe=%b busy=%b expected 0 0 0",
                         i, rw_done, dq_oe, data_busy);
            end
        end
    endtask

    task automatic test_preamble();
        logic e_dqs14;
`ifdef WR_PREAMBLE_EN
        e_dqs14 = 1'b1;
`else
        e_dqs14 = 1'b0;
`endif
        apply_reset();
        issue(10, c_WR, 5'd0, 5'd0, 5'd5, 4'd8, 64'h0706050403020100);
        goto(t0 + 13);
        checks++;
        if (dqs_oe !== 1'b0 || dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL pre_c13: got dqs=%b oe=%b expected 0 0", dqs_oe, dq_oe);
        end
        goto(t0 + 14);
        checks++;
        if (dqs_oe !== e_dqs14 || dq_oe !== 1'b0 || dq_out !== 16'h0) begin
            errors++;
            $display("FAIL pre_c14: got dqs=%b oe=%b dq=%h expected %b 0 0000",
                     dqs_oe, dq_oe, dq_out, e_dqs14);
        end
        goto(t0 + 15);
        checks++;
        if (dqs_oe !== 1'b1 || dq_oe !== 1'b1 || dq_out !== 16'h0100) begin
            errors++;
            $display("FAIL pre_c15: got dqs=%b oe=%b dq=%h expected 1 1 0100", dqs_oe, dq_oe, dq_out);
        end
        goto(t0 + 18);
        checks++;
        if (dq_oe !== 1'b1 || dq_out !== 16'h0706) begin
            errors++;
            $display("FAIL pre_c18: got oe=%b dq=%h expected 1 0706", dq_oe, dq_out);
        end
        goto(t0 + 19);
        checks++;
        if (rw_done !== 1'b1 || dqs_oe !== 1'b0) begin
            errors++;
            $display("FAIL pre_c19: got done=%b dqs=%b expected 1 0", rw_done, dqs_oe);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_conflict();
        test_clamp_latch();
        test_reset_midburst();
        test_preamble();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
